// File: rtl/enc_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the pending priority encoder.
//   MODE_FIXED / MODE_RR : arbitration mode selectors for the MODE parameter.
//   onehot(idx, n)       : 64-bit one-hot of idx, zero when idx is outside 0..n-1.
//                          Callers size-cast the result down to their own width,
//                          so designs using it are limited to 64 request lines.
// ----------------------------------------------------------------------------
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic logic [63:0] onehot(input int idx, input int n);
        if (idx >= 0 && idx < n && idx < 64) begin
            return 64'd1 << idx;
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// ----------------------------------------------------------------------------
// priority_pick
// Combinational selector over a request vector.
//   vec_i    [N] : candidate bits
//   start_i  [W] : first index examined in round-robin mode (must be < N)
//   rr_en_i      : 0 = highest set index wins, 1 = first set bit at or after
//                  start_i, wrapping N-1 -> 0
//   found_o      : at least one bit of vec_i is set
//   idx_o    [W] : chosen index (0 when found_o is low)
// ----------------------------------------------------------------------------
module priority_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    input  logic         rr_en_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   tmp;
    int             off;
    int             pos;

    assign dbl = {vec_i, vec_i};

    always_comb begin
        found_o = |vec_i;
        idx_o   = '0;
        // rot[k] holds vec_i[(start_i + k) mod N], so the lowest set bit of
        // rot is the nearest request at or after start_i.
        rot     = N'(dbl >> start_i);
        tmp     = '0;
        off     = 0;
        pos     = 0;
        if (!rr_en_i) begin
            // Ascending scan: the last hit is the highest index.
            for (int i = 0; i < N; i++) begin
                tmp = vec_i >> i;
                if (tmp[0]) begin
                    idx_o = W'(i);
                end
            end
        end else begin
            // Descending scan: the last hit is the smallest offset.
            for (int k = N - 1; k >= 0; k--) begin
                tmp = rot >> k;
                if (tmp[0]) begin
                    off = k;
                end
            end
            pos = int'(start_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (found_o) begin
                idx_o = W'(pos);
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// ----------------------------------------------------------------------------
// pending_priority_encoder
// Captures events on N request lines into a pending register and offers them
// one at a time as a binary index on a registered valid/ready output.
//   clk          : clock, all state changes on the rising edge
//   rst_n        : synchronous active-low reset (priority over clr_i)
//   req_i    [N] : request lines (level or rising-edge capture, see EDGE)
//   clr_i        : synchronous flush of pending, output slot, overflow, pointer
//   out_valid_o  : out_idx_o holds an event awaiting acceptance
//   out_idx_o[W] : index of the offered event
//   out_ready_i  : consumer accepts when high together with out_valid_o
//   pending_o[N] : pending vector (the offered index is not included)
//   overflow_o   : sticky, an event hit a bit that was already pending
// MODE selects fixed priority (highest index) or round-robin. N <= 64.
// ----------------------------------------------------------------------------
module pending_priority_encoder
    import enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = MODE_FIXED,
    parameter int EDGE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         clr_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_idx_o,
    input  logic         out_ready_i,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    localparam logic RR_EN = (MODE == MODE_RR);

    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] req_q;
    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] ev;
    logic         found;
    logic [W-1:0] sel;
    logic         load;
    logic [N-1:0] sel_mask;

    priority_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .vec_i   (pend_q),
        .start_i (ptr_q),
        .rr_en_i (RR_EN),
        .found_o (found),
        .idx_o   (sel)
    );

    assign ev       = (EDGE != 0) ? (req_i & ~req_q) : req_i;
    assign load     = found && (!valid_q || out_ready_i);
    assign sel_mask = load ? N'(onehot(int'(sel), N)) : '0;

    always_comb begin
        pend_d  = (pend_q & ~sel_mask) | ev;   // new event wins over the clear
        ovf_d   = ovf_q | (|(ev & pend_q & ~sel_mask));
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = sel;
            if (RR_EN) begin
                ptr_d = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_i) begin
            pend_d  = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= '0;
            req_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            req_q   <= req_i;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_idx_o   = idx_q;
    assign pending_o   = pend_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
module tb_pending_priority_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: fixed/level, B: fixed/edge, C: round-robin/level
    logic [3:0] req_a = '0, req_b = '0, req_c = '0;
    logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
    logic       va, vb, vc;
    logic [1:0] ia, ib, ic;
    logic [3:0] pa, pb, pc;
    logic       oa, ob, oc;

    int total = 0;
    int bad   = 0;

    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] qc[$];

    pending_priority_encoder #(.N(4), .MODE(0), .EDGE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .clr_i(clr_a),
        .out_valid_o(va), .out_idx_o(ia), .out_ready_i(rdy_a),
        .pending_o(pa), .overflow_o(oa));

    pending_priority_encoder #(.N(4), .MODE(0), .EDGE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .clr_i(clr_b),
        .out_valid_o(vb), .out_idx_o(ib), .out_ready_i(rdy_b),
        .pending_o(pb), .overflow_o(ob));

    pending_priority_encoder #(.N(4), .MODE(1), .EDGE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .req_i(req_c), .clr_i(clr_c),
        .out_valid_o(vc), .out_idx_o(ic), .out_ready_i(rdy_c),
        .pending_o(pc), .overflow_o(oc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on a handshake that completes at the coming edge.
    task automatic hs(input int k, input logic v, input logic r, input logic [1:0] got);
        logic [1:0] e;
        int         sz;
        if (v === 1'b1 && r === 1'b1) begin
            sz = (k == 0) ? qa.size() : (k == 1) ? qb.size() : qc.size();
            total++;
            assert (sz != 0) else begin
                bad++;
                $error("FAIL hs%0d_unexpected got=%0d expected=none", k, got);
            end
            if (sz != 0) begin
                case (k)
                    0:       e = qa.pop_front();
                    1:       e = qb.pop_front();
                    default: e = qc.pop_front();
                endcase
                total++;
                assert (got === e) else begin
                    bad++;
                    $error("FAIL hs%0d_idx got=%0d expected=%0d", k, got, e);
                end
            end
        end
    endtask

    task automatic tick();
        hs(0, va, rdy_a, ia);
        hs(1, vb, rdy_b, ib);
        hs(2, vc, rdy_c, ic);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all lines asserted
        rst_n = 1'b0;
        req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
        tick();
        tick();
        chk("rst_valid", 32'(va), 0);
        chk("rst_idx", 32'(ia), 0);
        chk("rst_pend", 32'(pa), 0);
        chk("rst_ovf", 32'(oa), 0);
        chk("rst_valid_b", 32'(vb), 0);
        chk("rst_valid_c", 32'(vc), 0);
        rst_n = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        tick();
        chk("post_rst_valid", 32'(va), 0);
        chk("post_rst_pend", 32'(pa), 0);
        tick();
        chk("post_rst_valid2", 32'(va), 0);

        // Fixed priority, edge capture
        rdy_b = 1'b1;
        req_b = 4'b1011;
        qb.push_back(2'd3); qb.push_back(2'd1); qb.push_back(2'd0);
        tick();
        chk("fix_pend", 32'(pb), 32'b1011);
        req_b = '0;
        repeat (4) tick();
        chk("fix_valid_end", 32'(vb), 0);
        chk("fix_ovf", 32'(ob), 0);
        chk("fix_drained", qb.size(), 0);

        // Round-robin, level held
        rdy_c = 1'b1;
        req_c = 4'b1111;
        qc.push_back(2'd0); qc.push_back(2'd1); qc.push_back(2'd2);
        qc.push_back(2'd3); qc.push_back(2'd0); qc.push_back(2'd1);
        tick();
        tick();
        chk("rr_first_valid", 32'(vc), 1);
        repeat (6) tick();
        rdy_c = 1'b0;
        req_c = '0;
        chk("rr_drained", qc.size(), 0);
        chk("rr_ovf_level", 32'(oc), 1);

        // Back-pressure
        rdy_b = 1'b0;
        req_b = 4'b0100;
        qb.push_back(2'd2); qb.push_back(2'd0);
        tick();
        req_b = '0;
        tick();
        chk("bp_valid", 32'(vb), 1);
        chk("bp_idx0", 32'(ib), 2);
        req_b = 4'b0001;
        tick();
        req_b = '0;
        chk("bp_idx1", 32'(ib), 2);
        chk("bp_pend1", 32'(pb), 32'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_idx_hold", 32'(ib), 2);
            chk("bp_valid_hold", 32'(vb), 1);
            chk("bp_pend_hold", 32'(pb), 32'b0001);
        end
        rdy_b = 1'b1;
        tick();
        chk("bp_next_idx", 32'(ib), 0);
        tick();
        chk("bp_valid_end", 32'(vb), 0);
        chk("bp_pend_end", 32'(pb), 0);
        chk("bp_drained", qb.size(), 0);

        // Overflow and flush
        rdy_b = 1'b0;
        req_b = 4'b0010;
        tick();
        req_b = '0;
        tick();
        chk("ovf_slot_valid", 32'(vb), 1);
        chk("ovf_slot_idx", 32'(ib), 1);
        chk("ovf_none0", 32'(ob), 0);
        req_b = 4'b0010;
        tick();
        req_b = '0;
        tick();
        chk("ovf_repend", 32'(pb), 32'b0010);
        chk("ovf_none1", 32'(ob), 0);
        req_b = 4'b0010;
        tick();
        req_b = '0;
        chk("ovf_set", 32'(ob), 1);
        tick();
        chk("ovf_sticky", 32'(ob), 1);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("clr_ovf", 32'(ob), 0);
        chk("clr_valid", 32'(vb), 0);
        chk("clr_pend", 32'(pb), 0);

        // Set/clear collision on a held level request
        rdy_a = 1'b1;
        req_a = 4'b0010;
        repeat (5) qa.push_back(2'd1);
        tick();
        tick();
        repeat (5) tick();
        rdy_a = 1'b0;
        chk("col_valid", 32'(va), 1);
        chk("col_idx", 32'(ia), 1);
        chk("col_pend", 32'(pa), 32'b0010);
        chk("col_ovf", 32'(oa), 0);
        chk("col_drained", qa.size(), 0);
        req_a = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
